// File: rtl/ram_port_master.sv
// Request-side controller for a single-port RAM whose read data is registered
// one cycle after the address, plus a block-fill engine that writes every location.
module ram_port_master #(
  parameter int AW = 6,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_wr,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  input  logic          fill_start,
  input  logic [DW-1:0] fill_value,
  output logic          fill_busy,
  output logic          fill_done,
  output logic          ram_we,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_di,
  output logic          ram_rst,
  input  logic [DW-1:0] ram_do
);

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_e;

  localparam logic [AW-1:0] LAST_ADDR = '1;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] fill_val_q, fill_val_d;
  logic          fill_done_q, fill_done_d;
  logic          rd_p1_q, rd_p1_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          req_fire;
  logic          rd_fire;

  assign ram_rst   = rst;
  assign req_ready = (state_q == IDLE) && !fill_start && !rst;
  assign req_fire  = req_valid && req_ready;
  assign rd_fire   = req_fire && !req_wr;

  assign fill_busy = (state_q == FILL);
  assign fill_done = fill_done_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      fill_val_q  <= '0;
      fill_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fill_val_q  <= fill_val_d;
      fill_done_q <= fill_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fill_val_d  = fill_val_q;
    fill_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (fill_start) begin
          state_d    = FILL;
          cnt_d      = '0;
          fill_val_d = fill_value;
        end
      end
      FILL: begin
        if (cnt_q == LAST_ADDR) begin
          state_d     = IDLE;
          cnt_d       = '0;
          fill_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The fill write is suppressed in a reset cycle so an aborted fill leaves
  // the current counter location untouched.
  always_comb begin
    ram_we = 1'b0;
    ram_a  = req_addr;
    ram_di = req_wdata;
    if (state_q == FILL) begin
      ram_we = !rst;
      ram_a  = cnt_q;
      ram_di = fill_val_q;
    end else begin
      ram_we = req_fire && req_wr;
    end
  end

  // Read pipeline: the RAM presents data the cycle after the address, and the
  // response register adds one more cycle, giving a fixed latency of two.
  always_comb begin
    rd_p1_d     = rd_fire;
    rsp_valid_d = rd_p1_q;
    rsp_data_d  = rd_p1_q ? ram_do : rsp_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_p1_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rd_p1_q     <= rd_p1_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

endmodule
